// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequencing controller for the shift-add multiplier datapath.
// It issues one strobe at a time: load, then add and shift per multiplier bit.
// It counts WIDTH shift iterations and flags completion with ready/done.
// Optional build macro MUL_SEQ_CTRL_PERF_EN adds cycle_cnt/last_cycles
// performance outputs.
module mul_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             product_lsb,
    output logic             wrctrl,
    output logic             strctrl,
    output logic             shctrl,
    output logic             ready,
    output logic             done,
    output logic [CNT_W-1:0] iter_cnt
`ifdef MUL_SEQ_CTRL_PERF_EN
    ,
    output logic [15:0]      cycle_cnt,
    output logic [15:0]      last_cycles
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        ADD,
        SHIFT,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    state_t state;

    // Moore FSM: each strobe is registered together with the state it belongs
    // to, so the outputs come straight from flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            iter_cnt <= '0;
            wrctrl   <= 1'b0;
            strctrl  <= 1'b0;
            shctrl   <= 1'b0;
            done     <= 1'b0;
            ready    <= 1'b1;
        end else begin
            wrctrl  <= 1'b0;
            strctrl <= 1'b0;
            shctrl  <= 1'b0;
            done    <= 1'b0;
            ready   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        iter_cnt <= '0;
                        wrctrl   <= 1'b1;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= CHECK;
                end
                CHECK: begin
                    if (iter_cnt == LAST_ITER) begin
                        state <= DONE;
                        done  <= 1'b1;
                        ready <= 1'b1;
                    end else if (product_lsb) begin
                        state   <= ADD;
                        strctrl <= 1'b1;
                    end else begin
                        state  <= SHIFT;
                        shctrl <= 1'b1;
                    end
                end
                ADD: begin
                    state  <= SHIFT;
                    shctrl <= 1'b1;
                end
                SHIFT: begin
                    state    <= CHECK;
                    iter_cnt <= iter_cnt + ONE;
                end
                DONE: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef MUL_SEQ_CTRL_PERF_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Cycle counter: loads 1 when entering LOAD and then counts every busy cycle.
    // The DONE cycle is included, and that total is captured into last_cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt   <= '0;
            last_cycles <= '0;
        end else begin
            if (state == IDLE) begin
                if (start) begin
                    cycle_cnt <= 16'd1;
                end
            end else if (state != DONE) begin
                cycle_cnt <= sat_inc(cycle_cnt);
            end
            if (state == CHECK && iter_cnt == LAST_ITER) begin
                last_cycles <= sat_inc(cycle_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl.
// A 65-bit product-register model is driven by the DUT strobes and feeds
// product_lsb back to the DUT.
// A reference trace is built per accepted start from the multiplier bits.
module tb_mul_seq_ctrl;
    localparam int W  = 32;
    localparam int CW = 6;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic product_lsb = 1'b0;
    logic wrctrl, strctrl, shctrl, ready, done;
    logic [CW-1:0] iter_cnt;
`ifdef MUL_SEQ_CTRL_PERF_EN
    logic [15:0] cycle_cnt, last_cycles;
`endif

    always #5 clk = ~clk;

    mul_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .product_lsb (product_lsb),
        .wrctrl      (wrctrl),
        .strctrl     (strctrl),
        .shctrl      (shctrl),
        .ready       (ready),
        .done        (done),
        .iter_cnt    (iter_cnt)
`ifdef MUL_SEQ_CTRL_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .last_cycles (last_cycles)
`endif
    );

    typedef struct packed {
        logic          wr;
        logic          str;
        logic          sh;
        logic          rdy;
        logic          dn;
        logic [CW-1:0] it;
    } exp_t;

    exp_t          q[$];
    exp_t          cur;
    logic [CW-1:0] idle_it;
    logic [64:0]   prod;
    logic [31:0]   mcand, acc_a, acc_b, op_a, op_b;
    int tests = 0, fails = 0;
    int cyc = 0, since = -1;
    int n_str, n_sh, n_done, add_viol, wr_cyc, done_cyc, wr_abs, done_abs;
    logic [CW-1:0] it_done;
    logic prev_str;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic exp_t mk(input logic wr, input logic str, input logic sh,
                                input logic rdy, input logic dn, input logic [CW-1:0] it);
        exp_t e;
        e.wr = wr; e.str = str; e.sh = sh; e.rdy = rdy; e.dn = dn; e.it = it;
        return e;
    endfunction

    // Expected cycle-by-cycle trace of one multiply, from the multiplier bits.
    function automatic void push_sched(input logic [31:0] b);
        q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0));
        for (int i = 0; i < W; i++) begin
            q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CW'(i)));
            if (b[i]) q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, CW'(i)));
            q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, CW'(i)));
        end
        q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CW'(W)));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, CW'(W)));
        idle_it = CW'(W);
    endfunction

    // One clock: model acceptance, compare at negedge, update datapath model.
    task automatic step();
        logic [10:0] av, ev;
        if (reset && start && cur.rdy && !cur.dn) begin
            acc_a = op_a;
            acc_b = op_b;
            push_sched(op_b);
            since = 0;
        end
        @(negedge clk);
        cyc++;
        if (since >= 0) since++;
        cur = (q.size() > 0) ? q.pop_front() : mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, idle_it);
        av = {wrctrl, strctrl, shctrl, ready, done, iter_cnt};
        ev = cur;
        check("outputs", 64'(av), 64'(ev));
        if (prev_str && !shctrl) add_viol++;
        prev_str = strctrl;
        if (strctrl) n_str++;
        if (shctrl) n_sh++;
        if (wrctrl) begin wr_cyc = since; wr_abs = cyc; end
        if (done) begin
            done_cyc = since; done_abs = cyc; n_done++; it_done = iter_cnt;
            check("product", prod[63:0], 64'(acc_a) * 64'(acc_b));
        end
        if (wrctrl) begin prod = {33'b0, acc_b}; mcand = acc_a; end
        if (strctrl) prod[64:32] = {1'b0, prod[63:32]} + {1'b0, mcand};
        if (shctrl) prod = prod >> 1;
        product_lsb = prod[0];
    endtask

    task automatic clear_stats();
        n_str = 0; n_sh = 0; n_done = 0; add_viol = 0;
        wr_cyc = -1; done_cyc = -1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && !(cur.rdy && !cur.dn); i++) step();
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        wait_idle();
        clear_stats();
        op_a = a; op_b = b;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 200 && done_cyc < 0; i++) step();
    endtask

    initial begin
        int d1, gap;
        logic [10:0] rv;
        cur = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        idle_it = '0; prod = '0; mcand = '0; acc_a = '0; acc_b = '0;
        op_a = '0; op_b = '0; prev_str = 1'b0; it_done = '0;
        wr_abs = 0; done_abs = 0;
        clear_stats();

        // Reset values.
        #12;
        rv = {wrctrl, strctrl, shctrl, ready, done, iter_cnt};
        check("reset_outputs", 64'(rv), 64'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0}));
        @(negedge clk);
        reset = 1'b1;
        repeat (3) step();

        // Multiplier 0.
        run_op(32'h1234_5678, 32'h0);
        check("zero_done_cycle", 64'(done_cyc), 64'd67);
        check("zero_wr_cycle", 64'(wr_cyc), 64'd1);
        check("zero_add_count", 64'(n_str), 64'd0);
        check("zero_shift_count", 64'(n_sh), 64'd32);
        check("zero_iter_at_done", 64'(it_done), 64'd32);
`ifdef MUL_SEQ_CTRL_PERF_EN
        check("perf_last_cycles", 64'(last_cycles), 64'd67);
`endif

        // Multiplier all ones.
        run_op(32'hDEAD_BEEF, 32'hFFFF_FFFF);
        check("ones_done_cycle", 64'(done_cyc), 64'd99);
        check("ones_add_count", 64'(n_str), 64'd32);
        check("ones_shift_count", 64'(n_sh), 64'd32);
        check("add_then_shift", 64'(add_viol), 64'd0);

        // Alternating bits.
        run_op(32'hFFFF_FFFF, 32'hAAAA_AAAA);
        check("alt_done_cycle", 64'(done_cyc), 64'd83);
        check("alt_add_count", 64'(n_str), 64'd16);

        // start pulses in CHECK and in DONE are ignored.
        wait_idle();
        clear_stats();
        op_a = 32'h0F0F_0F0F; op_b = 32'h1234_5678;
        start = 1'b1; step(); start = 1'b0;
        step();
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 200 && !done; i++) step();
        start = 1'b1; step(); start = 1'b0;
        repeat (6) step();
        check("single_done", 64'(n_done), 64'd1);

        // start held high: back-to-back operations.
        wait_idle();
        op_a = $urandom; op_b = 32'h0000_00F0;
        d1 = -1; gap = -1;
        start = 1'b1;
        for (int i = 0; i < 400 && gap < 0; i++) begin
            step();
            if (done && d1 < 0) d1 = cyc;
            else if (d1 >= 0 && wrctrl) gap = cyc - d1;
        end
        start = 1'b0;
        check("b2b_gap", 64'(gap), 64'd2);

        // Asynchronous reset in the ADD state of iteration 5.
        wait_idle();
        op_a = $urandom; op_b = $urandom | 32'h0000_0020;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 100 && !(cur.str && cur.it == 6'd5); i++) step();
        check("reached_add5", 64'({cur.str, cur.it}), 64'({1'b1, 6'd5}));
        reset = 1'b0;
        #1;
        rv = {wrctrl, strctrl, shctrl, ready, done, iter_cnt};
        check("abort_outputs", 64'(rv), 64'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0}));
        q.delete();
        idle_it = '0; since = -1; prod = '0; product_lsb = 1'b0; prev_str = 1'b0;
        cur = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        step();
        reset = 1'b1;
        clear_stats();
        repeat (10) step();
        check("no_strobes_after_abort", 64'(n_str + n_sh + n_done), 64'd0);

        // Randomized traffic with start pulses at arbitrary times.
        for (int i = 0; i < 2500; i++) begin
            int unsigned sel;
            sel = $urandom_range(0, 7);
            op_a = $urandom;
            op_b = (sel == 0) ? 32'h0 : (sel == 1) ? 32'hFFFF_FFFF : $urandom;
            start = ($urandom_range(0, 3) == 0);
            step();
        end
        start = 1'b0;
        wait_idle();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
